// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state encoding and constants for the pipeline control blocks
package cpu_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         CNT_W_DEF = 32;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en && (q != {CNT_W{1'b1}})) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RAW stall, redirect flush and RUN/HALT control for the 5-stage pipeline
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter bit HAS_FWD = 1'b1,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_ra,
    input  logic [4:0]       id_rb,
    input  logic             id_use_ra,
    input  logic             id_use_rb,
    input  logic [4:0]       ex_rw,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic [4:0]       mem_rw,
    input  logic             mem_regwrite,
    input  logic             ex_redirect,
    input  logic             ex_halt,
    input  logic             go,
    output logic             pc_pause,
    output logic             ifid_pause,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t state;
    logic   go_q;
    logic   ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic   haz_a, haz_b, stall;
    logic   in_run;

    // With forwarding only a load still in EX cannot supply its result in time.
    always_comb begin
        if (HAS_FWD) begin
            ex_hit_a  = ex_regwrite & ex_memtoreg & (ex_rw == id_ra);
            ex_hit_b  = ex_regwrite & ex_memtoreg & (ex_rw == id_rb);
            mem_hit_a = 1'b0;
            mem_hit_b = 1'b0;
        end else begin
            ex_hit_a  = ex_regwrite & (ex_rw == id_ra);
            ex_hit_b  = ex_regwrite & (ex_rw == id_rb);
            mem_hit_a = mem_regwrite & (mem_rw == id_ra);
            mem_hit_b = mem_regwrite & (mem_rw == id_rb);
        end
        haz_a = id_use_ra & (id_ra != REG_ZERO) & (ex_hit_a | mem_hit_a);
        haz_b = id_use_rb & (id_rb != REG_ZERO) & (ex_hit_b | mem_hit_b);
        stall = haz_a | haz_b;
    end

    assign in_run = ~rst & (state == RUN);

    always_comb begin
        pc_pause   = 1'b0;
        ifid_pause = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if ((state == HALT) || ex_halt) begin
            pc_pause   = 1'b1;
            ifid_pause = 1'b1;
            idex_flush = 1'b1;
        end else if (ex_redirect) begin
            // The ID instruction is wrong-path, so any stall it raised is moot.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall) begin
            pc_pause   = 1'b1;
            ifid_pause = 1'b1;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            halted <= 1'b0;
            go_q   <= 1'b0;
        end else begin
            go_q <= go;
            case (state)
                RUN: begin
                    if (ex_halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (go && !go_q) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .en  (in_run),
        .q   (cycle_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (in_run & ~ex_halt & ~ex_redirect & stall),
        .q   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .en  (in_run & ~ex_halt & ex_redirect),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for both forwarding variants of the hazard controller
module tb_pipeline_hazard_ctrl;

    localparam int W   = 8;
    localparam int MAX = (1 << W) - 1;

    typedef struct packed {
        logic       rst;
        logic [4:0] ra;
        logic [4:0] rb;
        logic       ua;
        logic       ub;
        logic [4:0] exrw;
        logic       exw;
        logic       exm;
        logic [4:0] memrw;
        logic       memw;
        logic       redir;
        logic       halt;
        logic       go;
    } in_t;

    typedef struct packed {
        logic [1:0][3:0]        ctrl;
        logic [1:0]             halted;
        logic [1:0][2:0][W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst, id_use_ra, id_use_rb, ex_regwrite, ex_memtoreg, mem_regwrite;
    logic ex_redirect, ex_halt, go;
    logic [4:0] id_ra, id_rb, ex_rw, mem_rw;

    logic [1:0]        pc_pause, ifid_pause, ifid_flush, idex_flush, halted;
    logic [1:0][W-1:0] cycle_cnt, stall_cnt, flush_cnt;

    int tests  = 0;
    int failed = 0;
    exp_t sb_q[$];

    int m_halted [2];
    int m_cnt    [2][3];
    int m_go_q;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.HAS_FWD(1'b1), .CNT_W(W)) dut_fwd (
        .clk(clk), .rst(rst), .id_ra(id_ra), .id_rb(id_rb),
        .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .ex_rw(ex_rw),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .mem_rw(mem_rw),
        .mem_regwrite(mem_regwrite), .ex_redirect(ex_redirect), .ex_halt(ex_halt),
        .go(go), .pc_pause(pc_pause[0]), .ifid_pause(ifid_pause[0]),
        .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]), .halted(halted[0]),
        .cycle_cnt(cycle_cnt[0]), .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
    );

    pipeline_hazard_ctrl #(.HAS_FWD(1'b0), .CNT_W(W)) dut_nofwd (
        .clk(clk), .rst(rst), .id_ra(id_ra), .id_rb(id_rb),
        .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .ex_rw(ex_rw),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .mem_rw(mem_rw),
        .mem_regwrite(mem_regwrite), .ex_redirect(ex_redirect), .ex_halt(ex_halt),
        .go(go), .pc_pause(pc_pause[1]), .ifid_pause(ifid_pause[1]),
        .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]), .halted(halted[1]),
        .cycle_cnt(cycle_cnt[1]), .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
    );

    // v=0 models the forwarding pipeline, v=1 the non-forwarding one.
    function automatic bit src_conflict(int v, in_t s, logic use_r, logic [4:0] r);
        if (!use_r || r == 5'd0) return 1'b0;
        if (v == 0) return s.exw && s.exm && s.exrw == r;
        return (s.exw && s.exrw == r) || (s.memw && s.memrw == r);
    endfunction

    function automatic bit model_stall(int v, in_t s);
        return src_conflict(v, s, s.ua, s.ra) || src_conflict(v, s, s.ub, s.rb);
    endfunction

    // Bit order: {pc_pause, ifid_pause, ifid_flush, idex_flush}
    function automatic logic [3:0] model_ctrl(int v, in_t s);
        if (s.rst) return 4'b0011;
        if (m_halted[v] != 0 || s.halt) return 4'b1101;
        if (s.redir) return 4'b0011;
        if (model_stall(v, s)) return 4'b1101;
        return 4'b0000;
    endfunction

    function automatic int bump(int x);
        return (x >= MAX) ? MAX : x + 1;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            m_halted[v] = 0;
            for (int k = 0; k < 3; k++) m_cnt[v][k] = 0;
        end
        m_go_q = 0;
    endtask

    task automatic step(input in_t s);
        exp_t e;
        rst = s.rst; id_ra = s.ra; id_rb = s.rb; id_use_ra = s.ua; id_use_rb = s.ub;
        ex_rw = s.exrw; ex_regwrite = s.exw; ex_memtoreg = s.exm; mem_rw = s.memrw;
        mem_regwrite = s.memw; ex_redirect = s.redir; ex_halt = s.halt; go = s.go;
        for (int v = 0; v < 2; v++) begin
            e.ctrl[v]   = model_ctrl(v, s);
            e.halted[v] = (m_halted[v] != 0);
            for (int k = 0; k < 3; k++) e.cnt[v][k] = W'(m_cnt[v][k]);
        end
        sb_q.push_back(e);
        if (s.rst) begin
            model_reset();
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (m_halted[v] != 0) begin
                    if (s.go && m_go_q == 0) m_halted[v] = 0;
                end else begin
                    m_cnt[v][0] = bump(m_cnt[v][0]);
                    if (s.halt) m_halted[v] = 1;
                    else if (s.redir) m_cnt[v][2] = bump(m_cnt[v][2]);
                    else if (model_stall(v, s)) m_cnt[v][1] = bump(m_cnt[v][1]);
                end
            end
            m_go_q = s.go;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int v, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s[v%0d] at %0t: got %0h expected %0h", name, v, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int v = 0; v < 2; v++) begin
                    check("ctrl", v, {28'd0, pc_pause[v], ifid_pause[v], ifid_flush[v], idex_flush[v]},
                          {28'd0, e.ctrl[v]});
                    check("halted", v, {31'd0, halted[v]}, {31'd0, e.halted[v]});
                    check("cycle_cnt", v, {24'd0, cycle_cnt[v]}, {24'd0, e.cnt[v][0]});
                    check("stall_cnt", v, {24'd0, stall_cnt[v]}, {24'd0, e.cnt[v][1]});
                    check("flush_cnt", v, {24'd0, flush_cnt[v]}, {24'd0, e.cnt[v][2]});
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        in_t s;
        in_t lu;
        int  drained;
        rst = 1'b1; id_ra = '0; id_rb = '0; id_use_ra = 1'b0; id_use_rb = 1'b0;
        ex_rw = '0; ex_regwrite = 1'b0; ex_memtoreg = 1'b0; mem_rw = '0;
        mem_regwrite = 1'b0; ex_redirect = 1'b0; ex_halt = 1'b0; go = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        s = '0; s.rst = 1'b1; step(s); step(s);
        s = '0; step(s);

        lu = '0; lu.exw = 1'b1; lu.exm = 1'b1; lu.exrw = 5'd5; lu.ra = 5'd5; lu.ua = 1'b1;
        step(lu);
        s = '0; step(s);

        s = lu; s.exrw = 5'd0; s.ra = 5'd0; step(s);
        s = lu; s.exm = 1'b0; step(s);
        s = '0; s.memw = 1'b1; s.memrw = 5'd7; s.rb = 5'd7; s.ub = 1'b1; step(s);

        s = lu; s.redir = 1'b1; step(s);
        s = '0; step(s);

        s = '0; s.halt = 1'b1; step(s);
        s = '0; repeat (10) step(s);
        s.go = 1'b1; step(s); step(s);
        s.go = 1'b0; step(s);

        s = '0; s.go = 1'b1; step(s);
        s.halt = 1'b1; step(s);
        s.halt = 1'b0; repeat (5) step(s);
        s.go = 1'b0; step(s); step(s);
        s.go = 1'b1; step(s); step(s);
        s.go = 1'b0; step(s);

        s = '0; s.halt = 1'b1; s.redir = 1'b1; step(s);
        s = '0; step(s);
        s.go = 1'b1; step(s);
        s.go = 1'b0; step(s);

        s = '0; s.halt = 1'b1; step(s);
        s = '0; step(s);
        s.rst = 1'b1; step(s);
        s.rst = 1'b0; step(s); step(s);

        s = lu; repeat (300) step(s);
        s = '0; s.halt = 1'b1; step(s);
        s = '0; repeat (3) step(s);
        s.go = 1'b1; step(s);

        s = '0;
        repeat (1500) begin
            s.rst   = ($urandom_range(0, 199) == 0);
            s.ra    = 5'($urandom_range(0, 3));
            s.rb    = 5'($urandom_range(0, 3));
            s.ua    = 1'($urandom_range(0, 1));
            s.ub    = 1'($urandom_range(0, 1));
            s.exrw  = 5'($urandom_range(0, 3));
            s.exw   = 1'($urandom_range(0, 1));
            s.exm   = 1'($urandom_range(0, 1));
            s.memrw = 5'($urandom_range(0, 3));
            s.memw  = 1'($urandom_range(0, 1));
            s.redir = ($urandom_range(0, 7) == 0);
            s.halt  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) s.go = ~s.go;
            step(s);
        end

        drained = 0;
        for (int i = 0; i < 5 && drained == 0; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) drained = 1;
        end
        tests++;
        if (drained == 0) begin
            failed++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
